fibo_seq_engine: RTL

Parametrised generalised-Fibonacci engine: computes X(n) where X(0)=seed0, X(1)=seed1, X(k)=X(k-1)+X(k-2) mod 2^DATA_W. It is the successor to the fixed 16-bit, fixed-seed Fibonacci calculator in the lab datapath. It adds configurable width, user seeds (covers Fibonacci and Lucas), valid/ready handshakes on both sides, and optional overflow reporting. It sits as a request/response slave behind the lab control FSM.

---
 rtl/fibo_pkg.sv | 15 +
 rtl/fibo_step.sv | 115 +++++++++++
 rtl/fibo_seq_engine.sv | 115 +++++++++++
 3 files changed

// File: rtl/fibo_pkg.sv
// fibo_pkg: shared definitions for the generalised-Fibonacci engine.
//   - default widths for the data path and the index
//   - controller state encoding
package fibo_pkg;

    localparam int FIBO_DATA_W = 16;
    localparam int FIBO_IDX_W  = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        HOLD    = 2'd2
    } fibo_state_t;

endpackage

// File: rtl/fibo_step.sv
// fibo_step: recurrence datapath for fibo_seq_engine.
// Holds the sliding pair (a, b) = (X(cnt), X(cnt+1)), the step counter and the
// latched target index. One step advances the pair by one index.
//
// Build option: FIBO_OVF_EN -- when defined, per-term wrap flags ride along with
// a and b; when undefined the tracking is not built and a_ovf is tied 0.
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   load         capture seeds and target index, clear counter and flags
//   step         advance the recurrence one index
//   n            target index (sampled on load)
//   seed0/seed1  X(0) / X(1) (sampled on load)
//   a            current X(cnt)
//   a_ovf        some X(k), k <= cnt, wrapped
//   done         cnt has reached the target index
module fibo_step
    import fibo_pkg::*;
#(
    parameter int DATA_W = FIBO_DATA_W,
    parameter int IDX_W  = FIBO_IDX_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [IDX_W-1:0]  n,
    input  logic [DATA_W-1:0] seed0,
    input  logic [DATA_W-1:0] seed1,
    output logic [DATA_W-1:0] a,
    output logic              a_ovf,
    output logic              done
);

    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  n_q, n_d;
    logic [DATA_W-1:0] sum;

`ifdef FIBO_OVF_EN
    logic [DATA_W:0] sum_full;
    logic            carry;
    logic            a_ovf_q, a_ovf_d;
    logic            b_ovf_q, b_ovf_d;

    assign sum_full = {1'b0, a_q} + {1'b0, b_q};
    assign sum      = sum_full[DATA_W-1:0];
    assign carry    = sum_full[DATA_W];

    // b's flag is sticky over the whole history: the new term wraps if either
    // predecessor had already wrapped or this addition carries out.
    always_comb begin
        a_ovf_d = a_ovf_q;
        b_ovf_d = b_ovf_q;
        if (load) begin
            a_ovf_d = 1'b0;
            b_ovf_d = 1'b0;
        end else if (step) begin
            a_ovf_d = b_ovf_q;
            b_ovf_d = a_ovf_q | b_ovf_q | carry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_ovf_q <= 1'b0;
            b_ovf_q <= 1'b0;
        end else begin
            a_ovf_q <= a_ovf_d;
            b_ovf_q <= b_ovf_d;
        end
    end

    assign a_ovf = a_ovf_q;
`else
    assign sum   = a_q + b_q;
    assign a_ovf = 1'b0;
`endif

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        cnt_d = cnt_q;
        n_d   = n_q;
        if (load) begin
            a_d   = seed0;
            b_d   = seed1;
            cnt_d = '0;
            n_d   = n;
        end else if (step) begin
            a_d   = b_q;
            b_d   = sum;
            cnt_d = cnt_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            n_q   <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            cnt_q <= cnt_d;
            n_q   <= n_d;
        end
    end

    assign a    = a_q;
    assign done = (cnt_q == n_q);

endmodule

// File: rtl/fibo_seq_engine.sv
// fibo_seq_engine: request/response generalised-Fibonacci engine.
// Computes X(n) with X(0)=seed0, X(1)=seed1, X(k)=X(k-1)+X(k-2) mod 2^DATA_W.
// Latency is n+1 cycles from accept to result_valid.
//
// Build option: FIBO_OVF_EN -- when defined, overflow reports wrap of any X(k)
// with k <= n; when undefined overflow is tied 0 (port retained).
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   start          request valid (accepted only in IDLE)
//   in_ready       request ready, high only in IDLE
//   n              target index
//   seed0, seed1   X(0), X(1)
//   result         X(n), stable while result_valid
//   result_valid   result valid (HOLD)
//   result_ready   consumer ready
//   overflow       some X(k), k <= n, wrapped; qualified by result_valid
//   busy           high in COMPUTE or HOLD
module fibo_seq_engine
    import fibo_pkg::*;
#(
    parameter int DATA_W = FIBO_DATA_W,
    parameter int IDX_W  = FIBO_IDX_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              in_ready,
    input  logic [IDX_W-1:0]  n,
    input  logic [DATA_W-1:0] seed0,
    input  logic [DATA_W-1:0] seed1,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              overflow,
    output logic              busy
);

    fibo_state_t       state_q, state_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              overflow_q, overflow_d;

    logic              load;
    logic              step;
    logic              done;
    logic [DATA_W-1:0] cur_a;
    logic              cur_ovf;

    fibo_step #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_step (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .step  (step),
        .n     (n),
        .seed0 (seed0),
        .seed1 (seed1),
        .a     (cur_a),
        .a_ovf (cur_ovf),
        .done  (done)
    );

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        load       = 1'b0;
        step       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                if (done) begin
                    result_d   = cur_a;
                    overflow_d = cur_ovf;
                    state_d    = HOLD;
                end else begin
                    step = 1'b1;
                end
            end
            HOLD: begin
                if (result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    // All handshake outputs decode registered state only.
    assign in_ready     = (state_q == IDLE);
    assign result_valid = (state_q == HOLD);
    assign busy         = (state_q == COMPUTE) || (state_q == HOLD);
    assign result       = result_q;
    assign overflow     = overflow_q;

endmodule
